// File: rtl/c_credit_tracker_pkg.sv
// ----------------------------------------------------------------------------
// c_credit_tracker_pkg
//   Shared constants and helpers for the credit tracker slice.
//   - RESET_TYPE_* : register reset styles; the tracker only supports async.
//   - clogb()      : ceil(log2(value)), used to size counters at elaboration.
// ----------------------------------------------------------------------------
package c_credit_tracker_pkg;

  localparam int RESET_TYPE_ASYNC = 0;
  localparam int RESET_TYPE_SYNC  = 1;

  // Number of bits needed to hold (value - 1); clogb(depth + 1) therefore
  // gives enough bits to represent 0..depth inclusive.
  function automatic int clogb(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/c_shift_reg.sv
// ----------------------------------------------------------------------------
// c_shift_reg
//   Fixed-length delay line with an enable. Every stage resets to zero, so
//   anything in flight is discarded when reset is asserted.
// Ports:
//   clk       in  1      clock
//   reset     in  1      asynchronous reset, active-low
//   active    in  1      shift enable; all stages hold when 0
//   data_in   in  width  value entering stage 0
//   data_out  out width  value leaving the last stage (depth cycles later)
// ----------------------------------------------------------------------------
module c_shift_reg #(
  parameter int width = 1,
  parameter int depth = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out
);

  logic [width-1:0] stage_q [depth];
  logic [width-1:0] stage_d [depth];

  always_comb begin
    for (int i = 0; i < depth; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (active) begin
      stage_d[0] = data_in;
      for (int i = 1; i < depth; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign data_out = stage_q[depth-1];

endmodule

// File: rtl/c_credit_tracker.sv
// ----------------------------------------------------------------------------
// c_credit_tracker
//   Upstream-side credit counter for a remote FIFO. The count starts at depth
//   (all slots free), drops on each debit (element sent) and rises on each
//   returned credit (remote pop). Status flags are registered from the next
//   count so no comparator sits on the output path.
// Parameters:
//   depth          remote FIFO entries; initial and maximum credit (>= 1)
//   credit_delay   register stages on the credit input before the counter
//   enable_bypass  1: a debit while full is legal if a delayed credit lands
//                  in the same cycle
//   reset_type     must be RESET_TYPE_ASYNC
// Ports:
//   clk           in   1          clock
//   reset         in   1          asynchronous reset, active-low
//   active        in   1          clock-gate enable; state holds when 0
//   debit         in   1          element sent downstream
//   credit        in   1          downstream pop reported
//   credit_count  out  cnt_width  free downstream slots
//   almost_full   out  1          exactly one credit left
//   full          out  1          no credits left
//   empty         out  1          all credits returned (count == depth)
//   errors        out  [0:1]      [0] underflow, [1] overflow (non-sticky)
// ----------------------------------------------------------------------------
module c_credit_tracker
  import c_credit_tracker_pkg::*;
#(
  parameter  int depth         = 8,
  parameter  int credit_delay  = 0,
  parameter  int enable_bypass = 0,
  parameter  int reset_type    = RESET_TYPE_ASYNC,
  localparam int cnt_width     = clogb(depth + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 debit,
  input  logic                 credit,
  output logic [cnt_width-1:0] credit_count,
  output logic                 almost_full,
  output logic                 full,
  output logic                 empty,
  output logic [0:1]           errors
);

  localparam logic [cnt_width-1:0] max_count = cnt_width'(depth);
  localparam logic [cnt_width-1:0] one_count = cnt_width'(1);
  localparam logic                 bypass_en = (enable_bypass != 0);
  localparam logic                 af_reset  = (depth == 1);

  if (depth < 1) begin : g_bad_depth
    $error("c_credit_tracker: depth must be at least 1");
  end

  if (reset_type != RESET_TYPE_ASYNC) begin : g_bad_reset_type
    $error("c_credit_tracker: only asynchronous reset is supported");
  end

  logic credit_d;

  if (credit_delay > 0) begin : g_credit_pipe
    c_shift_reg #(
      .width (1),
      .depth (credit_delay)
    ) u_credit_pipe (
      .clk      (clk),
      .reset    (reset),
      .active   (active),
      .data_in  (credit),
      .data_out (credit_d)
    );
  end else begin : g_credit_direct
    assign credit_d = credit;
  end

  logic [cnt_width-1:0] count_q, count_d;
  logic                 full_q, full_d;
  logic                 almost_full_q, almost_full_d;
  logic                 empty_q, empty_d;
  logic [cnt_width-1:0] next_count;
  logic                 underflow;
  logic                 overflow;

  // Errors look at the current inputs even when active is low; an erroring
  // cycle leaves the count where it is so the counter can never wrap.
  always_comb begin
    underflow     = debit & full_q & ~(bypass_en & credit_d);
    overflow      = credit_d & empty_q & ~debit;
    next_count    = count_q;
    count_d       = count_q;
    full_d        = full_q;
    almost_full_d = almost_full_q;
    empty_d       = empty_q;

    if (!underflow && !overflow) begin
      if (credit_d && !debit) begin
        next_count = count_q + one_count;
      end else if (debit && !credit_d) begin
        next_count = count_q - one_count;
      end
    end

    if (active) begin
      count_d       = next_count;
      full_d        = (next_count == '0);
      almost_full_d = (next_count == one_count);
      empty_d       = (next_count == max_count);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= max_count;
      full_q        <= 1'b0;
      almost_full_q <= af_reset;
      empty_q       <= 1'b1;
    end else begin
      count_q       <= count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      empty_q       <= empty_d;
    end
  end

  assign credit_count = count_q;
  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign errors[0]    = underflow;
  assign errors[1]    = overflow;

endmodule

// File: tb/tb_c_credit_tracker.sv
// ----------------------------------------------------------------------------
// tb_c_credit_tracker
//   Four tracker instances sharing clock, reset and active:
//     0: depth 8, no delay, no bypass
//     1: depth 8, no delay, bypass enabled
//     2: depth 8, credit delay 2, no bypass
//     3: depth 1, no delay, no bypass
//   Each stimulus step drives one instance and queues the hand-computed
//   values expected at the following falling edge; a separate monitor pops
//   and compares them.
// ----------------------------------------------------------------------------
module tb_c_credit_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       active;
  logic [3:0] deb;
  logic [3:0] cred;

  logic [3:0] cnt0, cnt1, cnt2;
  logic [0:0] cnt3;
  logic       af0, af1, af2, af3;
  logic       fl0, fl1, fl2, fl3;
  logic       em0, em1, em2, em3;
  logic [0:1] err0, err1, err2, err3;

  c_credit_tracker #(.depth(8), .credit_delay(0), .enable_bypass(0)) u_plain (
    .clk(clk), .reset(rst_n), .active(active), .debit(deb[0]), .credit(cred[0]),
    .credit_count(cnt0), .almost_full(af0), .full(fl0), .empty(em0), .errors(err0)
  );

  c_credit_tracker #(.depth(8), .credit_delay(0), .enable_bypass(1)) u_bypass (
    .clk(clk), .reset(rst_n), .active(active), .debit(deb[1]), .credit(cred[1]),
    .credit_count(cnt1), .almost_full(af1), .full(fl1), .empty(em1), .errors(err1)
  );

  c_credit_tracker #(.depth(8), .credit_delay(2), .enable_bypass(0)) u_delay (
    .clk(clk), .reset(rst_n), .active(active), .debit(deb[2]), .credit(cred[2]),
    .credit_count(cnt2), .almost_full(af2), .full(fl2), .empty(em2), .errors(err2)
  );

  c_credit_tracker #(.depth(1), .credit_delay(0), .enable_bypass(0)) u_single (
    .clk(clk), .reset(rst_n), .active(active), .debit(deb[3]), .credit(cred[3]),
    .credit_count(cnt3), .almost_full(af3), .full(fl3), .empty(em3), .errors(err3)
  );

  // Packed as {count[3:0], almost_full, full, empty, underflow, overflow}
  typedef struct {
    string      name;
    int         inst;
    logic [8:0] exp;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic logic [8:0] observe(input int inst);
    logic [8:0] v;
    case (inst)
      0:       v = {cnt0, af0, fl0, em0, err0[0], err0[1]};
      1:       v = {cnt1, af1, fl1, em1, err1[0], err1[1]};
      2:       v = {cnt2, af2, fl2, em2, err2[0], err2[1]};
      default: v = {3'b000, cnt3, af3, fl3, em3, err3[0], err3[1]};
    endcase
    return v;
  endfunction

  // Drive one cycle of stimulus for a single instance and queue what that
  // instance should show before the next rising edge.
  task automatic apply_stimulus(input string name, input int inst,
                                input logic r, input logic a,
                                input logic d, input logic c,
                                input int cnt, input logic af, input logic fl,
                                input logic em, input logic uf, input logic of);
    item_t it;
    @(posedge clk);
    #1;
    rst_n      = r;
    active     = a;
    deb        = '0;
    cred       = '0;
    deb[inst]  = d;
    cred[inst] = c;
    it.name    = name;
    it.inst    = inst;
    it.exp     = {4'(cnt), af, fl, em, uf, of};
    exp_q.push_back(it);
  endtask

  function automatic void check_output(input item_t it);
    logic [8:0] act;
    act      = observe(it.inst);
    n_checks = n_checks + 1;
    if (act !== it.exp) begin
      n_errors = n_errors + 1;
      $display("[TB] FAIL %s (inst %0d): got cnt=%0d af/full/empty=%b uf/of=%b, expected cnt=%0d af/full/empty=%b uf/of=%b",
               it.name, it.inst, act[8:5], act[4:2], act[1:0],
               it.exp[8:5], it.exp[4:2], it.exp[1:0]);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check_output(exp_q.pop_front());
    end
  end

  initial begin
    rst_n  = 1'b0;
    active = 1'b1;
    deb    = '0;
    cred   = '0;

    // Reset values
    apply_stimulus("rst_d8", 0, 0, 1, 0, 0, 8, 0, 0, 1, 0, 0);
    apply_stimulus("rst_d1", 3, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0);

    // Overflow at empty, then credit and debit together at empty
    apply_stimulus("empty_ovf",  0, 1, 1, 0, 1, 8, 0, 0, 1, 0, 1);
    apply_stimulus("empty_both", 0, 1, 1, 1, 1, 8, 0, 0, 1, 0, 0);
    apply_stimulus("empty_idle", 0, 1, 1, 0, 0, 8, 0, 0, 1, 0, 0);

    // Eight back-to-back debits, then a ninth into full
    for (int k = 0; k < 8; k++) begin
      apply_stimulus("drain", 0, 1, 1, 1, 0, 8 - k,
                     logic'((8 - k) == 1), 0, logic'(k == 0), 0, 0);
    end
    apply_stimulus("deb9_uf",   0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0);
    apply_stimulus("full_both", 0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0);
    apply_stimulus("full_idle", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    // Bypass instance: drain, then debit and credit together while full
    for (int k = 0; k < 8; k++) begin
      apply_stimulus("byp_drain", 1, 1, 1, 1, 0, 8 - k,
                     logic'((8 - k) == 1), 0, logic'(k == 0), 0, 0);
    end
    apply_stimulus("byp_both",  1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    apply_stimulus("byp_cred",  1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    apply_stimulus("byp_after", 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);

    // Delayed credit: count 5, credit at cycle N shows up at N+3
    apply_stimulus("dly_deb",  2, 1, 1, 1, 0, 8, 0, 0, 1, 0, 0);
    apply_stimulus("dly_deb",  2, 1, 1, 1, 0, 7, 0, 0, 0, 0, 0);
    apply_stimulus("dly_deb",  2, 1, 1, 1, 0, 6, 0, 0, 0, 0, 0);
    apply_stimulus("dly_cred", 2, 1, 1, 0, 1, 5, 0, 0, 0, 0, 0);
    apply_stimulus("dly_n1",   2, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0);
    apply_stimulus("dly_n2",   2, 1, 1, 0, 0, 5, 0, 0, 0, 0, 0);
    apply_stimulus("dly_n3",   2, 1, 1, 0, 0, 6, 0, 0, 0, 0, 0);

    // Reset mid-stream with a credit still in the pipeline
    apply_stimulus("mid_deb",  2, 1, 1, 1, 0, 6, 0, 0, 0, 0, 0);
    apply_stimulus("mid_deb",  2, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0);
    apply_stimulus("mid_deb",  2, 1, 1, 1, 0, 4, 0, 0, 0, 0, 0);
    apply_stimulus("mid_cred", 2, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0);
    apply_stimulus("mid_rst",  2, 0, 1, 0, 0, 8, 0, 0, 1, 0, 0);
    apply_stimulus("post_rst", 2, 1, 1, 0, 0, 8, 0, 0, 1, 0, 0);
    apply_stimulus("post_rst", 2, 1, 1, 0, 0, 8, 0, 0, 1, 0, 0);
    apply_stimulus("post_rst", 2, 1, 1, 0, 0, 8, 0, 0, 1, 0, 0);

    // Single-entry remote FIFO
    apply_stimulus("d1_deb",   3, 1, 1, 1, 0, 1, 1, 0, 1, 0, 0);
    apply_stimulus("d1_uf",    3, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0);
    apply_stimulus("d1_cred",  3, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    apply_stimulus("d1_ovf",   3, 1, 1, 0, 1, 1, 1, 0, 1, 0, 1);
    apply_stimulus("d1_after", 3, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0);

    // Clock gating: state holds, errors still reported
    apply_stimulus("act_deb",   0, 1, 0, 1, 0, 8, 0, 0, 1, 0, 0);
    apply_stimulus("act_ovf",   0, 1, 0, 0, 1, 8, 0, 0, 1, 0, 1);
    apply_stimulus("act_on",    0, 1, 1, 1, 0, 8, 0, 0, 1, 0, 0);
    apply_stimulus("act_after", 0, 1, 1, 0, 0, 7, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    deb  = '0;
    cred = '0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    n_checks = n_checks + 1;
    if (exp_q.size() != 0) begin
      n_errors = n_errors + 1;
      $display("[TB] FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
